// File: rtl/ex_operand_stage_if.sv
// Bundle of handshake and data buses around the ID/EX operand stage.
// master: decode/MEM/WB/ALU side (drives id_*, mem_*, wb_*, flush, ex_ready).
// slave : the operand stage itself.
interface ex_operand_stage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            flush;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_imm;
  logic [RA_W-1:0] id_rs1_addr;
  logic [RA_W-1:0] id_rs2_addr;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic            id_use_pc;
  logic            id_use_imm;
  logic            id_alu_op;
  logic [RA_W-1:0] id_rd_addr;
  logic            id_rd_we;
  logic [RA_W-1:0] mem_rd_addr;
  logic            mem_rd_we;
  logic [XLEN-1:0] mem_rd_data;
  logic [RA_W-1:0] wb_rd_addr;
  logic            wb_rd_we;
  logic [XLEN-1:0] wb_rd_data;
  logic            ex_valid;
  logic            ex_ready;
  logic            ex_alu_op;
  logic [XLEN-1:0] ex_in1;
  logic [XLEN-1:0] ex_in2;
  logic [RA_W-1:0] ex_rd_addr;
  logic            ex_rd_we;
  logic [31:0]     stall_cnt;

  modport master (
    output flush, id_valid, id_pc, id_imm, id_rs1_addr, id_rs2_addr,
           id_rs1_data, id_rs2_data, id_use_pc, id_use_imm, id_alu_op,
           id_rd_addr, id_rd_we, mem_rd_addr, mem_rd_we, mem_rd_data,
           wb_rd_addr, wb_rd_we, wb_rd_data, ex_ready,
    input  id_ready, ex_valid, ex_alu_op, ex_in1, ex_in2, ex_rd_addr,
           ex_rd_we, stall_cnt
  );

  modport slave (
    input  flush, id_valid, id_pc, id_imm, id_rs1_addr, id_rs2_addr,
           id_rs1_data, id_rs2_data, id_use_pc, id_use_imm, id_alu_op,
           id_rd_addr, id_rd_we, mem_rd_addr, mem_rd_we, mem_rd_data,
           wb_rd_addr, wb_rd_we, wb_rd_data, ex_ready,
    output id_ready, ex_valid, ex_alu_op, ex_in1, ex_in2, ex_rd_addr,
           ex_rd_we, stall_cnt
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: one-entry valid/ready slot holding a decoded
// instruction, drives ALU op/in1/in2, counts back-pressure cycles.
// Optional MEM/WB operand forwarding enabled by macro EX_OPERAND_FWD_EN.
module ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  ex_operand_stage_if.slave bus
);

  // Source operands are handled as a 2-entry array: index 0 = rs1, 1 = rs2.
  localparam int NUM_SRC = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            use_pc;
    logic            use_imm;
    logic            alu_op;
    logic [RA_W-1:0] rd_addr;
    logic            rd_we;
  } ex_entry_t;

  ex_entry_t                         ent_q, ent_d;
  logic                              vld_q, vld_d;
  logic [NUM_SRC-1:0][RA_W-1:0]      rs_addr_q, rs_addr_d;
  logic [NUM_SRC-1:0][XLEN-1:0]      rs_data_q, rs_data_d;
  logic [31:0]                       stall_cnt_q, stall_cnt_d;

  logic [NUM_SRC-1:0][RA_W-1:0]      id_rs_addr;
  logic [NUM_SRC-1:0][XLEN-1:0]      id_rs_data;
  logic [NUM_SRC-1:0][XLEN-1:0]      rs_eff;
  logic                              capture;
  logic                              hold;

  assign id_rs_addr = {bus.id_rs2_addr, bus.id_rs1_addr};
  assign id_rs_data = {bus.id_rs2_data, bus.id_rs1_data};

  // Flush opens the slot so an in-flight beat handshakes and is dropped.
  assign bus.id_ready = !vld_q || bus.ex_ready || bus.flush;
  assign capture      = bus.id_valid && bus.id_ready && !bus.flush;
  assign hold         = vld_q && !bus.ex_ready;

  // Slot next-state: flush > capture > retire; hold-time WB refresh.
  always_comb begin
    vld_d     = vld_q;
    ent_d     = ent_q;
    rs_addr_d = rs_addr_q;
    rs_data_d = rs_data_q;
    if (bus.flush) begin
      vld_d = 1'b0;
    end else if (capture) begin
      vld_d         = 1'b1;
      ent_d.pc      = bus.id_pc;
      ent_d.imm     = bus.id_imm;
      ent_d.use_pc  = bus.id_use_pc;
      ent_d.use_imm = bus.id_use_imm;
      ent_d.alu_op  = bus.id_alu_op;
      ent_d.rd_addr = bus.id_rd_addr;
      ent_d.rd_we   = bus.id_rd_we;
      rs_addr_d     = id_rs_addr;
      rs_data_d     = id_rs_data;
`ifdef EX_OPERAND_FWD_EN
      // The regfile read in ID misses the WB write of this same cycle.
      for (int s = 0; s < NUM_SRC; s++)
        if (bus.wb_rd_we && bus.wb_rd_addr == id_rs_addr[s] && id_rs_addr[s] != '0)
          rs_data_d[s] = bus.wb_rd_data;
`endif
    end else if (vld_q && bus.ex_ready) begin
      vld_d = 1'b0;
    end
`ifdef EX_OPERAND_FWD_EN
    // While stalled, absorb WB writes so the value outlives the WB stage.
    if (hold && !bus.flush)
      for (int s = 0; s < NUM_SRC; s++)
        if (bus.wb_rd_we && bus.wb_rd_addr == rs_addr_q[s] && rs_addr_q[s] != '0)
          rs_data_d[s] = bus.wb_rd_data;
`endif
  end

  // Effective source values: MEM result beats WB beats stored data.
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      rs_eff[s] = rs_data_q[s];
`ifdef EX_OPERAND_FWD_EN
      if (bus.mem_rd_we && bus.mem_rd_addr == rs_addr_q[s] && rs_addr_q[s] != '0)
        rs_eff[s] = bus.mem_rd_data;
      else if (bus.wb_rd_we && bus.wb_rd_addr == rs_addr_q[s] && rs_addr_q[s] != '0)
        rs_eff[s] = bus.wb_rd_data;
`endif
    end
  end

`ifndef EX_OPERAND_FWD_EN
  // Forwarding ports and stored source addresses have no role here.
  logic unused_fwd;
  assign unused_fwd = ^{bus.mem_rd_addr, bus.mem_rd_we, bus.mem_rd_data,
                        bus.wb_rd_addr, bus.wb_rd_we, bus.wb_rd_data, rs_addr_q};
`endif

  // Saturating back-pressure counter; only reset clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hold && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q       <= 1'b0;
      ent_q       <= '0;
      rs_addr_q   <= '0;
      rs_data_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      vld_q       <= vld_d;
      ent_q       <= ent_d;
      rs_addr_q   <= rs_addr_d;
      rs_data_q   <= rs_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.ex_valid   = vld_q;
  assign bus.ex_alu_op  = ent_q.alu_op;
  assign bus.ex_in1     = ent_q.use_pc  ? ent_q.pc  : rs_eff[0];
  assign bus.ex_in2     = ent_q.use_imm ? ent_q.imm : rs_eff[1];
  assign bus.ex_rd_addr = ent_q.rd_addr;
  assign bus.ex_rd_we   = ent_q.rd_we;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: handshake, stall, flush, forwarding.
module tb_ex_operand_stage;

`ifdef EX_OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ex_operand_stage_if #(.XLEN(32), .RA_W(5)) bus ();

  ex_operand_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush       = 1'b0;
    bus.id_valid    = 1'b0;
    bus.id_pc       = '0;
    bus.id_imm      = '0;
    bus.id_rs1_addr = '0;
    bus.id_rs2_addr = '0;
    bus.id_rs1_data = '0;
    bus.id_rs2_data = '0;
    bus.id_use_pc   = 1'b0;
    bus.id_use_imm  = 1'b0;
    bus.id_alu_op   = 1'b0;
    bus.id_rd_addr  = '0;
    bus.id_rd_we    = 1'b0;
    bus.mem_rd_addr = '0;
    bus.mem_rd_we   = 1'b0;
    bus.mem_rd_data = '0;
    bus.wb_rd_addr  = '0;
    bus.wb_rd_we    = 1'b0;
    bus.wb_rd_data  = '0;
    bus.ex_ready    = 1'b0;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst_in1",   bus.ex_in1, 32'd0);
    chk("rst_in2",   bus.ex_in2, 32'd0);
    chk("rst_stall", bus.stall_cnt, 32'd0);
    chk("rst_idrdy", {31'd0, bus.id_ready}, 32'd1);

    // first beat: in1=rs1, in2=imm, sub
    bus.ex_ready    = 1'b1;
    bus.id_valid    = 1'b1;
    bus.id_rs1_addr = 5'd1;
    bus.id_rs1_data = 32'h10;
    bus.id_imm      = 32'h5;
    bus.id_use_imm  = 1'b1;
    bus.id_alu_op   = 1'b1;
    bus.id_rd_addr  = 5'd7;
    bus.id_rd_we    = 1'b1;
    tick();
    chk("b0_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("b0_in1",   bus.ex_in1, 32'h10);
    chk("b0_in2",   bus.ex_in2, 32'h5);
    chk("b0_op",    {31'd0, bus.ex_alu_op}, 32'd1);
    chk("b0_rd",    {27'd0, bus.ex_rd_addr}, 32'd7);
    chk("b0_rdwe",  {31'd0, bus.ex_rd_we}, 32'd1);

    // 4 back-to-back beats, in2 from rs2
    for (int i = 0; i < 4; i++) begin
      bus.id_use_imm  = 1'b0;
      bus.id_rs1_data = 32'h100 + i;
      bus.id_rs2_data = 32'h200 + i;
      bus.id_alu_op   = i[0];
      tick();
      chk("str_valid", {31'd0, bus.ex_valid}, 32'd1);
      chk("str_in1",   bus.ex_in1, 32'h100 + i);
      chk("str_in2",   bus.ex_in2, 32'h200 + i);
      chk("str_op",    {31'd0, bus.ex_alu_op}, {31'd0, i[0]});
    end

    // back-pressure for 3 cycles with a new beat waiting
    bus.ex_ready    = 1'b0;
    bus.id_use_pc   = 1'b1;
    bus.id_pc       = 32'h1000;
    bus.id_rs2_data = 32'h400;
    bus.id_alu_op   = 1'b0;
    #1;
    chk("stl_idrdy0", {31'd0, bus.id_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl_valid", {31'd0, bus.ex_valid}, 32'd1);
      chk("stl_in1",   bus.ex_in1, 32'h103);
      chk("stl_in2",   bus.ex_in2, 32'h203);
      chk("stl_op",    {31'd0, bus.ex_alu_op}, 32'd1);
      chk("stl_idrdy", {31'd0, bus.id_ready}, 32'd0);
    end
    chk("stl_cnt3", bus.stall_cnt, 32'd3);
    bus.ex_ready = 1'b1;
    #1;
    chk("rel_idrdy", {31'd0, bus.id_ready}, 32'd1);
    tick();
    chk("rel_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("rel_in1",   bus.ex_in1, 32'h1000);
    chk("rel_in2",   bus.ex_in2, 32'h400);
    chk("rel_cnt",   bus.stall_cnt, 32'd3);

    // flush with ex_ready=1 and an incoming beat
    bus.flush     = 1'b1;
    bus.id_use_pc = 1'b0;
    bus.id_rs1_data = 32'h55;
    #1;
    chk("fl1_idrdy", {31'd0, bus.id_ready}, 32'd1);
    tick();
    bus.flush    = 1'b0;
    bus.id_valid = 1'b0;
    #1;
    chk("fl1_valid", {31'd0, bus.ex_valid}, 32'd0);
    tick();
    chk("fl1_drop",  {31'd0, bus.ex_valid}, 32'd0);

    // flush with ex_ready=0
    bus.id_valid   = 1'b1;
    bus.id_use_imm = 1'b1;
    bus.id_imm     = 32'h77;
    tick();
    chk("fl2_pre",   {31'd0, bus.ex_valid}, 32'd1);
    chk("fl2_in2",   bus.ex_in2, 32'h77);
    bus.ex_ready = 1'b0;
    bus.flush    = 1'b1;
    #1;
    chk("fl2_idrdy", {31'd0, bus.id_ready}, 32'd1);
    tick();
    bus.flush    = 1'b0;
    bus.id_valid = 1'b0;
    #1;
    chk("fl2_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("fl2_cnt",   bus.stall_cnt, 32'd4);
    tick();
    chk("fl2_drop",  {31'd0, bus.ex_valid}, 32'd0);

    // forwarding on rs1 = x3
    bus.ex_ready    = 1'b1;
    bus.id_valid    = 1'b1;
    bus.id_rs1_addr = 5'd3;
    bus.id_rs1_data = 32'h11;
    bus.id_imm      = 32'h0;
    tick();
    bus.id_valid    = 1'b0;
    bus.ex_ready    = 1'b0;
    bus.mem_rd_we   = 1'b1;
    bus.mem_rd_addr = 5'd3;
    bus.mem_rd_data = 32'hAA;
    bus.wb_rd_we    = 1'b1;
    bus.wb_rd_addr  = 5'd3;
    bus.wb_rd_data  = 32'hBB;
    #1;
    chk("fw_mem", bus.ex_in1, FWD ? 32'hAA : 32'h11);
    bus.mem_rd_we = 1'b0;
    #1;
    chk("fw_wb",  bus.ex_in1, FWD ? 32'hBB : 32'h11);
    bus.wb_rd_data = 32'hCC;
    tick();
    bus.wb_rd_we = 1'b0;
    #1;
    chk("fw_hold",  bus.ex_in1, FWD ? 32'hCC : 32'h11);
    tick();
    chk("fw_hold2", bus.ex_in1, FWD ? 32'hCC : 32'h11);

    // rs1 = x0 never forwarded
    bus.ex_ready    = 1'b1;
    bus.id_valid    = 1'b1;
    bus.id_rs1_addr = 5'd0;
    bus.id_rs1_data = 32'h22;
    tick();
    bus.id_valid    = 1'b0;
    bus.ex_ready    = 1'b0;
    bus.mem_rd_we   = 1'b1;
    bus.mem_rd_addr = 5'd0;
    bus.mem_rd_data = 32'hEE;
    bus.wb_rd_we    = 1'b1;
    bus.wb_rd_addr  = 5'd0;
    bus.wb_rd_data  = 32'hDD;
    #1;
    chk("x0_fwd",  bus.ex_in1, 32'h22);
    tick();
    chk("x0_hold", bus.ex_in1, 32'h22);
    bus.mem_rd_we = 1'b0;
    bus.wb_rd_we  = 1'b0;
    #1;
    chk("x0_idle", bus.ex_in1, 32'h22);

    // capture bypass from WB on rs1 = x5
    bus.ex_ready    = 1'b1;
    bus.id_valid    = 1'b1;
    bus.id_rs1_addr = 5'd5;
    bus.id_rs1_data = 32'h33;
    bus.wb_rd_we    = 1'b1;
    bus.wb_rd_addr  = 5'd5;
    bus.wb_rd_data  = 32'h44;
    tick();
    bus.id_valid = 1'b0;
    bus.wb_rd_we = 1'b0;
    #1;
    chk("cap_byp", bus.ex_in1, FWD ? 32'h44 : 32'h33);
    chk("cap_vld", {31'd0, bus.ex_valid}, 32'd1);

    // asynchronous reset with an entry held
    bus.ex_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("arst_cnt",   bus.stall_cnt, 32'd0);
    chk("arst_in1",   bus.ex_in1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
